// File: rtl/sram_pkg.sv
// Shared state type and byte-lane merge helper for the byte-enable SRAM
// with built-in zero-fill engine.
package sram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {CLEAR, IDLE} sram_state_t;

   // One byte lane of a byte-enable write: new byte where enabled, old byte otherwise.
   function automatic logic [BYTE_W-1:0] be_merge(
      input logic [BYTE_W-1:0] old_b,
      input logic [BYTE_W-1:0] new_b,
      input logic              be
   );
      return be ? new_b : old_b;
   endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear-engine controller: walks every address once after reset or on
// request, flags busy while doing so and reports accesses dropped meanwhile.
module sram_init_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic              busy,
   output logic              reject,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam int DEPTH = 2**ADDR_W;

   sram_state_t       r_state;
   sram_state_t       w_state_next;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [ADDR_W-1:0] w_clr_cnt_next;
   logic              r_reject;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_clr_cnt <= '0;
         r_reject  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_clr_cnt <= w_clr_cnt_next;
         r_reject  <= (r_state == CLEAR) && (wr_en || rd_en);
      end
   end

   // init_req is only honoured from IDLE, so a running clear is never restarted.
   always_comb begin
      w_state_next   = r_state;
      w_clr_cnt_next = r_clr_cnt;
      case (r_state)
         CLEAR: begin
            w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
            if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
               w_state_next = IDLE;
            end
         end
         IDLE: begin
            if (init_req) begin
               w_clr_cnt_next = '0;
               w_state_next   = CLEAR;
            end
         end
         default: w_state_next = CLEAR;
      endcase
   end

   assign busy     = (r_state == CLEAR);
   assign clr_we   = (r_state == CLEAR);
   assign clr_addr = r_clr_cnt;
   assign reject   = r_reject;

endmodule

// File: rtl/sram_be_init.sv
// Simple dual-port SRAM with byte-enable writes, registered write-first read
// and a zero-fill engine that locks out user accesses while it runs.
module sram_be_init
   import sram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init_req,
   output logic                     busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/BYTE_W-1:0] wr_be,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     reject
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W / BYTE_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [NB-1:0]     w_wbe;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_rd_word;

   sram_init_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .init_req (init_req),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .busy     (w_busy),
      .reject   (reject),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   assign w_wr_acc = wr_en && !w_busy;
   assign w_rd_acc = rd_en && !w_busy;

   // The clear engine owns the write port while busy: all-lanes write of zero.
   assign w_we    = w_clr_we || w_wr_acc;
   assign w_waddr = w_clr_we ? w_clr_addr : wr_addr;
   assign w_wdata = w_clr_we ? '0 : wr_data;
   assign w_wbe   = w_clr_we ? '1 : wr_be;

   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (w_we && w_wbe[b]) begin
            r_mem[w_waddr][b*BYTE_W +: BYTE_W] <= w_wdata[b*BYTE_W +: BYTE_W];
         end
      end
   end

   assign w_fwd_hit = w_wr_acc && (wr_addr == rd_addr);

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
         assign w_rd_word[gi*BYTE_W +: BYTE_W] =
            be_merge(r_mem[rd_addr][gi*BYTE_W +: BYTE_W],
                     wr_data[gi*BYTE_W +: BYTE_W],
                     w_fwd_hit && wr_be[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_data <= w_rd_word;
         end
      end
   end

   assign busy     = w_busy;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sram_be_init.sv
// Randomised scoreboard bench for sram_be_init (32-bit words, 16 deep).
module tb_sram_be_init;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int NB    = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_req = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] wr_be = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          busy;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          reject;

   sram_be_init #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .init_req (init_req),
      .busy     (busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .reject   (reject)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: word array plus "edges of clearing still to go".
   logic [DW-1:0] m_mem [DEPTH];
   int            busy_left = DEPTH;
   logic          exp_reject = 1'b0;
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_data = '0;
   logic [DW-1:0] popped;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                             input logic ir);
      if (busy_left > 0) begin
         exp_reject = we || re;
         exp_valid  = 1'b0;
         busy_left--;
      end else begin
         exp_reject = 1'b0;
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
            end
         end
         exp_valid = re;
         if (re) exp_q.push_back(m_mem[ra]);
         if (ir) begin
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            busy_left = DEPTH;
         end
      end
   endtask

   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                       input logic ir);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra; init_req = ir;
      @(posedge clk);
      if (!rst) model_edge(we, wa, wd, be, re, ra, ir);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst        = 1'b1;
      busy_left  = DEPTH;
      exp_reject = 1'b0;
      exp_valid  = 1'b0;
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
      idle(n);
      rst = 1'b0;
   endtask

   task automatic rand_step(input logic ir);
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 1)), wa, DW'($urandom), NB'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ra, ir);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      chk("busy", DW'(busy), DW'(busy_left > 0));
      chk("reject", DW'(reject), DW'(exp_reject));
      chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
      if (rst) begin
         last_data = '0;
         chk("rd_data_reset", rd_data, '0);
      end else if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got %08h expected no read at %0t", rd_data, $time);
         end else begin
            popped = exp_q.pop_front();
            chk("rd_data", rd_data, popped);
            last_data = popped;
            $display("txn read data=%08h expected=%08h", rd_data, popped);
         end
      end else begin
         chk("rd_data_hold", rd_data, last_data);
      end
   end

   initial begin
      do_reset(2);
      idle(DEPTH + 1);

      // Every word reads back as zero after the power-on clear.
      for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);

      // Byte-enable merge, then an all-disabled write that must change nothing.
      step(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, '0, 1'b0);
      step(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      step(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd3, 1'b0);

      // Write-first forwarding on a same-address read.
      step(1'b1, 4'd5, 32'h0000007E, 4'b0001, 1'b1, 4'd5, 1'b0);
      idle(1);

      // Fill with ones, clear on request while hammering the ports, read back.
      for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), '1, '1, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      repeat (DEPTH) rand_step(1'b1);
      for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);

      // Reset during a running clear, with a read in flight just before it.
      step(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b1);
      repeat (7) rand_step(1'b0);
      do_reset(2);
      repeat (DEPTH + 2) rand_step(1'b0);

      // Streaming reads of addr*3, one result per cycle.
      for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), DW'(a * 3), '1, 1'b0, '0, 1'b0);
      for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
      idle(1);

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 200) == 0) do_reset(1);
         else rand_step(1'($urandom_range(0, 40) == 0));
      end

      idle(3);
      chk("queue_drained", DW'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
